mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS datapath. It sequences FETCH/DECODE/EXEC/MEM/WB and drives every datapath select, including the immediate-extender op.
- Replaces the single-cycle combinational controller. It sits between the IR (opcode/funct) and the PC, GRF, ALU, extender and data-memory port.
- The data-memory access is a req/ack handshake, so the FSM can stall on slow memory.

Parameters:
WAIT_LIMIT, 0, max cycles spent in MEM waiting for dm_ack; 0 = wait forever
CNT_W, 32, width of the retired-instruction counter (optional feature only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
opcode  in  6  IR[31:26], stable from DECODE until the next FETCH
funct  in  6  IR[5:0]
zero  in  1  ALU equal flag, valid in EXEC
dm_ack  in  1  data memory done; sampled only in MEM
ir_we  out  1  IR load
pc_we  out  1  PC load
npc_sel  out  2  00 pc+4, 01 branch, 10 jump26, 11 rs
ext_op  out  2  00 zero-ext, 01 sign-ext, 10 lui (imm<<16)
alu_op  out  3  000 add, 001 sub, 010 or
alu_src  out  1  0 rt, 1 ext out
reg_dst  out  2  00 rt, 01 rd, 10 $31
wd_sel  out  2  00 alu, 01 dm, 10 pc (already pc+4)
reg_we  out  1  GRF write
dm_req  out  1  data memory request
dm_we  out  1  store qualifier, valid with dm_req
illegal  out  1  one-cycle pulse on undecodable instruction
bus_err  out  1  one-cycle pulse on MEM timeout
state  out  3  current state, for debug

Behaviour:
- Supported instructions: addu, subu, ori, lw, sw, beq, lui, jal, jr, nop (opcode 0, funct 0).
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- Reset:
  - Reset is sampled at the clk edge; state goes to FETCH.
  - While reset=0, all enables/pulses (ir_we, pc_we, reg_we, dm_req, dm_we, illegal, bus_err) are 0.
  - All selects read 0, except ext_op=01.
- Outputs are decoded combinationally from state plus opcode/funct, and are gated by reset.
- FETCH: ir_we=1, pc_we=1, npc_sel=00 -> DECODE.
- DECODE:
  - jal: pc_we=1, npc_sel=10, reg_we=1, reg_dst=10, wd_sel=10 -> FETCH.
  - jr: pc_we=1, npc_sel=11 -> FETCH.
  - nop: -> FETCH with no writes.
  - Undecodable: illegal=1 -> FETCH.
  - Otherwise -> EXEC.
- EXEC:
  - beq: alu_op=sub, alu_src=0, pc_we=zero, npc_sel=01 -> FETCH.
  - lw/sw -> MEM. R-type/ori/lui -> WB.
- MEM:
  - dm_req=1; dm_we=1 for sw.
  - If dm_ack=1 on the first MEM cycle: single-cycle MEM.
  - Stay in MEM while dm_ack=0.
  - On ack: lw -> WB, sw -> FETCH.
- WB: reg_we=1; lw wd_sel=01, others 00; R-type reg_dst=01, others 00 -> FETCH.
- ext_op, valid DECODE..WB: ori=00; lw/sw/beq=01; lui=10; everything else 01.
- alu_op: addu/lw/sw/lui=add, subu/beq=sub, ori=or. alu_src=1 for all I-type except beq.
- Latency per instruction: jal/jr/nop 2 cycles, beq 3, R/ori/lui 4, sw 4+wait, lw 5+wait.
- Timeout:
  - When WAIT_LIMIT>0, a wait counter clears on MEM entry.
  - If dm_ack is still 0 after WAIT_LIMIT MEM cycles: bus_err=1, dm_req drops, -> FETCH with no reg write.
  - An ack arriving on the limit cycle wins over the timeout.
- dm_ack outside MEM is ignored.
- Reset mid-MEM: request aborted, no writeback, state=FETCH on the next edge.

Optional Feature:
- Macro MC_CTRL_PERF_EN.
- When defined:
  - Adds output instr_cnt [CNT_W-1:0].
  - instr_cnt increments on every completing transition back to FETCH, except illegal or bus_err exits.
  - It wraps modulo 2^CNT_W and is reset to 0.
- When undefined: no port, no counter logic.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode/funct constants;
  - state encoding;
  - ext_op, npc_sel, alu_op, reg_dst and wd_sel encodings.
- Sub-module mc_ctrl_dec: purely combinational opcode/funct -> instruction class plus ext_op/alu_op/alu_src/reg_dst. The FSM instantiates it.

Test Plan:
- Reset low for 2 cycles mid-MEM of an lw -> next cycle state=0, dm_req=0, reg_we never asserted; after release, FETCH asserts ir_we/pc_we.
- ori (opcode 001101), then lui (001111), then lw (100011) -> ext_op 00, 10, 01 respectively during DECODE..WB; latencies 4, 4, 5 with dm_ack tied 1.
- beq (000100) with zero=1 -> pc_we=1, npc_sel=01 in EXEC; with zero=0 -> pc_we=0; both return to FETCH after 3 cycles.
- sw with dm_ack delayed 3 cycles, WAIT_LIMIT=0 -> dm_req/dm_we held 4 cycles, then FETCH. With WAIT_LIMIT=2 and no ack -> bus_err pulse, FETCH.
- jal (000011) -> single DECODE cycle with reg_dst=10, wd_sel=10, reg_we=1, npc_sel=10. Opcode 111111 -> illegal pulse, no writes.
- With MC_CTRL_PERF_EN and CNT_W=4: run 17 valid instructions -> instr_cnt=1; an illegal instruction leaves the count unchanged.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// FSM states, instruction classes and the datapath select codes.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_NOP   = 6'b000000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_ADDU, C_SUBU, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_JAL, C_JR, C_NOP, C_ILL
  } iclass_t;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_J26  = 2'b10;
  localparam logic [1:0] NPC_RS   = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;

  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_RA    = 2'b10;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_DM    = 2'b01;
  localparam logic [1:0] WD_PC    = 2'b10;

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational instruction decoder: opcode/funct to instruction class plus
// the state-independent datapath selects (extender, ALU, ALU source, reg dest).
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic [1:0] ext_op,
  output logic [2:0] alu_op,
  output logic       alu_src,
  output logic [1:0] reg_dst
);

  always_comb begin
    iclass = C_ILL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: iclass = C_ADDU;
          FN_SUBU: iclass = C_SUBU;
          FN_JR:   iclass = C_JR;
          FN_NOP:  iclass = C_NOP;
          default: iclass = C_ILL;
        endcase
      end
      OP_ORI:  iclass = C_ORI;
      OP_LUI:  iclass = C_LUI;
      OP_LW:   iclass = C_LW;
      OP_SW:   iclass = C_SW;
      OP_BEQ:  iclass = C_BEQ;
      OP_JAL:  iclass = C_JAL;
      default: iclass = C_ILL;
    endcase
  end

  // Sign-extend / add / rt-source is the fallback for anything not listed.
  always_comb begin
    ext_op  = EXT_SIGN;
    alu_op  = ALU_ADD;
    alu_src = 1'b0;
    reg_dst = RD_RT;
    case (iclass)
      C_ADDU: reg_dst = RD_RD;
      C_SUBU: begin
        alu_op  = ALU_SUB;
        reg_dst = RD_RD;
      end
      C_ORI: begin
        ext_op  = EXT_ZERO;
        alu_op  = ALU_OR;
        alu_src = 1'b1;
      end
      C_LW, C_SW: alu_src = 1'b1;
      C_BEQ:  alu_op = ALU_SUB;
      C_LUI: begin
        ext_op  = EXT_LUI;
        alu_src = 1'b1;
      end
      C_JAL:  reg_dst = RD_RA;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with a req/ack data-memory handshake and
// optional MEM timeout. Macro MC_CTRL_PERF_EN adds a retired-instruction counter.
//
// state  | meaning
// FETCH  | load IR, PC <= PC+4
// DECODE | decode; jal/jr/nop/illegal finish here
// EXEC   | ALU op; beq resolves here
// MEM    | dm_req held until dm_ack or timeout
// WB     | GRF write from ALU or data memory
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 0
`ifdef MC_CTRL_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       dm_ack,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] npc_sel,
  output logic [1:0] ext_op,
  output logic [2:0] alu_op,
  output logic       alu_src,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       reg_we,
  output logic       dm_req,
  output logic       dm_we,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
`ifdef MC_CTRL_PERF_EN
  , output logic [CNT_W-1:0] instr_cnt
`endif
);

  state_t     state_q, state_d;
  iclass_t    iclass;
  logic [1:0] dec_ext;
  logic [2:0] dec_alu;
  logic       dec_src;
  logic [1:0] dec_reg_dst;
  logic       timeout;

  mc_ctrl_dec u_dec (
    .opcode  (opcode),
    .funct   (funct),
    .iclass  (iclass),
    .ext_op  (dec_ext),
    .alu_op  (dec_alu),
    .alu_src (dec_src),
    .reg_dst (dec_reg_dst)
  );

  // Down-counter loaded in EXEC so it is fresh on every MEM entry.
  localparam int WT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  generate
    if (WAIT_LIMIT > 0) begin : g_wait
      logic [WT_W-1:0] wait_q;
      always_ff @(posedge clk) begin
        if (!reset)
          wait_q <= '0;
        else if (state_q == S_EXEC)
          wait_q <= WT_W'(WAIT_LIMIT - 1);
        else if (state_q == S_MEM && wait_q != '0)
          wait_q <= wait_q - 1'b1;
      end
      assign timeout = (state_q == S_MEM) && !dm_ack && (wait_q == '0);
    end else begin : g_nowait
      assign timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (iclass)
          C_JAL, C_JR, C_NOP, C_ILL: state_d = S_FETCH;
          default:                   state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (iclass)
          C_LW, C_SW: state_d = S_MEM;
          C_BEQ:      state_d = S_FETCH;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        // An ack on the limit cycle takes priority over the timeout.
        if (dm_ack) begin
          if (iclass == C_LW) state_d = S_WB;
          else                state_d = S_FETCH;
        end else if (timeout) begin
          state_d = S_FETCH;
        end
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    npc_sel = NPC_PC4;
    ext_op  = EXT_SIGN;
    alu_op  = ALU_ADD;
    alu_src = 1'b0;
    reg_dst = RD_RT;
    wd_sel  = WD_ALU;
    reg_we  = 1'b0;
    dm_req  = 1'b0;
    dm_we   = 1'b0;
    illegal = 1'b0;
    bus_err = 1'b0;
    if (reset) begin
      if (state_q != S_FETCH) begin
        ext_op  = dec_ext;
        alu_op  = dec_alu;
        alu_src = dec_src;
      end
      case (state_q)
        S_FETCH: begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
        S_DECODE: begin
          case (iclass)
            C_JAL: begin
              pc_we   = 1'b1;
              npc_sel = NPC_J26;
              reg_we  = 1'b1;
              reg_dst = dec_reg_dst;
              wd_sel  = WD_PC;
            end
            C_JR: begin
              pc_we   = 1'b1;
              npc_sel = NPC_RS;
            end
            C_ILL:   illegal = 1'b1;
            default: ;
          endcase
        end
        S_EXEC: begin
          if (iclass == C_BEQ) begin
            pc_we   = zero;
            npc_sel = NPC_BR;
          end
        end
        S_MEM: begin
          dm_req  = 1'b1;
          dm_we   = (iclass == C_SW);
          bus_err = timeout;
        end
        S_WB: begin
          reg_we  = 1'b1;
          reg_dst = dec_reg_dst;
          if (iclass == C_LW) wd_sel = WD_DM;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

`ifdef MC_CTRL_PERF_EN
  logic retire;
  assign retire = reset && (state_q != S_FETCH) && (state_d == S_FETCH)
                  && !illegal && !bus_err;

  always_ff @(posedge clk) begin
    if (!reset)      instr_cnt <= '0;
    else if (retire) instr_cnt <= instr_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: one instance waits forever in MEM, the other
// times out after two MEM cycles. Perf-counter checks run when MC_CTRL_PERF_EN is set.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset, zero, dm_ack;
  logic [5:0] opcode, funct;

  logic       ir_we_a, pc_we_a, alu_src_a, reg_we_a, dm_req_a, dm_we_a, illegal_a, bus_err_a;
  logic [1:0] npc_sel_a, ext_op_a, reg_dst_a, wd_sel_a;
  logic [2:0] alu_op_a, state_a;
  logic       ir_we_b, pc_we_b, alu_src_b, reg_we_b, dm_req_b, dm_we_b, illegal_b, bus_err_b;
  logic [1:0] npc_sel_b, ext_op_b, reg_dst_b, wd_sel_b;
  logic [2:0] alu_op_b, state_b;
`ifdef MC_CTRL_PERF_EN
  logic [3:0]  cnt_a;
  logic [31:0] cnt_b;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_ctrl #(.WAIT_LIMIT(0)
`ifdef MC_CTRL_PERF_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .dm_ack(dm_ack),
    .ir_we(ir_we_a), .pc_we(pc_we_a), .npc_sel(npc_sel_a), .ext_op(ext_op_a),
    .alu_op(alu_op_a), .alu_src(alu_src_a), .reg_dst(reg_dst_a), .wd_sel(wd_sel_a),
    .reg_we(reg_we_a), .dm_req(dm_req_a), .dm_we(dm_we_a), .illegal(illegal_a),
    .bus_err(bus_err_a), .state(state_a)
`ifdef MC_CTRL_PERF_EN
    , .instr_cnt(cnt_a)
`endif
  );

  mc_ctrl #(.WAIT_LIMIT(2)) dut_to (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .dm_ack(dm_ack),
    .ir_we(ir_we_b), .pc_we(pc_we_b), .npc_sel(npc_sel_b), .ext_op(ext_op_b),
    .alu_op(alu_op_b), .alu_src(alu_src_b), .reg_dst(reg_dst_b), .wd_sel(wd_sel_b),
    .reg_we(reg_we_b), .dm_req(dm_req_b), .dm_we(dm_we_b), .illegal(illegal_b),
    .bus_err(bus_err_b), .state(state_b)
`ifdef MC_CTRL_PERF_EN
    , .instr_cnt(cnt_b)
`endif
  );

  logic [21:0] obs_a, obs_b;
  assign obs_a = {ir_we_a, pc_we_a, npc_sel_a, ext_op_a, alu_op_a, alu_src_a, reg_dst_a,
                  wd_sel_a, reg_we_a, dm_req_a, dm_we_a, illegal_a, bus_err_a, state_a};
  assign obs_b = {ir_we_b, pc_we_b, npc_sel_b, ext_op_b, alu_op_b, alu_src_b, reg_dst_b,
                  wd_sel_b, reg_we_b, dm_req_b, dm_we_b, illegal_b, bus_err_b, state_b};

  // Field order: ir pc npc ext alu src rdst wd rwe req we ill berr state
  function automatic logic [21:0] ov(input logic ir, input logic pc, input logic [1:0] npc,
                                     input logic [1:0] ext, input logic [2:0] alu, input logic src,
                                     input logic [1:0] rdst, input logic [1:0] wd, input logic rwe,
                                     input logic req, input logic we, input logic ill,
                                     input logic berr, input logic [2:0] st);
    return {ir, pc, npc, ext, alu, src, rdst, wd, rwe, req, we, ill, berr, st};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc_a(input string tag, input logic [21:0] e);
    #1 chk(tag, {10'd0, obs_a}, {10'd0, e});
    @(posedge clk); #1;
  endtask

  task automatic cyc_b(input string tag, input logic [21:0] e);
    #1 chk(tag, {10'd0, obs_b}, {10'd0, e});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  localparam logic [21:0] V_RST   = 22'b0000_0100_0000_0000_0000_00 | 22'd0;
  localparam logic [21:0] V_FETCH = 22'b1100_0100_0000_0000_0000_00;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; opcode = 6'b0; funct = 6'b0; zero = 1'b0; dm_ack = 1'b0;
    @(posedge clk); #1;
    cyc_a("rst_state", ov(0,0,0,1,0,0,0,0,0,0,0,0,0,0));
    reset = 1'b1;

    // lw aborted by a two-cycle reset while stalled in MEM
    opcode = 6'b100011;
    cyc_a("lwr_f", V_FETCH);
    cyc_a("lwr_d", ov(0,0,0,1,0,1,0,0,0,0,0,0,0,1));
    cyc_a("lwr_e", ov(0,0,0,1,0,1,0,0,0,0,0,0,0,2));
    cyc_a("lwr_m", ov(0,0,0,1,0,1,0,0,0,1,0,0,0,3));
    reset = 1'b0;
    #1 chk("rst_mid_req", {31'd0, dm_req_a}, 32'd0);
    chk("rst_mid_rwe", {31'd0, reg_we_a}, 32'd0);
    @(posedge clk); #1;
    cyc_a("rst_mid2", ov(0,0,0,1,0,0,0,0,0,0,0,0,0,0));
    reset = 1'b1;

    // ori, lui, lw back-to-back with dm_ack tied high
    dm_ack = 1'b1;
    opcode = 6'b001101;
    cyc_a("ori_f", V_FETCH);
    cyc_a("ori_d", ov(0,0,0,0,2,1,0,0,0,0,0,0,0,1));
    cyc_a("ori_e", ov(0,0,0,0,2,1,0,0,0,0,0,0,0,2));
    cyc_a("ori_w", ov(0,0,0,0,2,1,0,0,1,0,0,0,0,4));
    opcode = 6'b001111;
    cyc_a("lui_f", V_FETCH);
    cyc_a("lui_d", ov(0,0,0,2,0,1,0,0,0,0,0,0,0,1));
    cyc_a("lui_e", ov(0,0,0,2,0,1,0,0,0,0,0,0,0,2));
    cyc_a("lui_w", ov(0,0,0,2,0,1,0,0,1,0,0,0,0,4));
    opcode = 6'b100011;
    cyc_a("lw_f", V_FETCH);
    cyc_a("lw_d", ov(0,0,0,1,0,1,0,0,0,0,0,0,0,1));
    cyc_a("lw_e", ov(0,0,0,1,0,1,0,0,0,0,0,0,0,2));
    cyc_a("lw_m", ov(0,0,0,1,0,1,0,0,0,1,0,0,0,3));
    cyc_a("lw_w", ov(0,0,0,1,0,1,0,1,1,0,0,0,0,4));
    dm_ack = 1'b0;

    // beq taken and not taken
    opcode = 6'b000100; zero = 1'b1;
    cyc_a("beq1_f", V_FETCH);
    cyc_a("beq1_d", ov(0,0,0,1,1,0,0,0,0,0,0,0,0,1));
    cyc_a("beq1_e", ov(0,1,1,1,1,0,0,0,0,0,0,0,0,2));
    zero = 1'b0;
    cyc_a("beq0_f", V_FETCH);
    cyc_a("beq0_d", ov(0,0,0,1,1,0,0,0,0,0,0,0,0,1));
    cyc_a("beq0_e", ov(0,0,1,1,1,0,0,0,0,0,0,0,0,2));

    // R-type addu / subu
    opcode = 6'b000000; funct = 6'b100001;
    cyc_a("addu_f", V_FETCH);
    cyc_a("addu_d", ov(0,0,0,1,0,0,0,0,0,0,0,0,0,1));
    cyc_a("addu_e", ov(0,0,0,1,0,0,0,0,0,0,0,0,0,2));
    cyc_a("addu_w", ov(0,0,0,1,0,0,1,0,1,0,0,0,0,4));
    funct = 6'b100011;
    cyc_a("subu_f", V_FETCH);
    cyc_a("subu_d", ov(0,0,0,1,1,0,0,0,0,0,0,0,0,1));
    cyc_a("subu_e", ov(0,0,0,1,1,0,0,0,0,0,0,0,0,2));
    cyc_a("subu_w", ov(0,0,0,1,1,0,1,0,1,0,0,0,0,4));

    // sw with ack on the fourth MEM cycle, no limit
    opcode = 6'b101011; funct = 6'b000000;
    cyc_a("sw_f", V_FETCH);
    cyc_a("sw_d", ov(0,0,0,1,0,1,0,0,0,0,0,0,0,1));
    cyc_a("sw_e", ov(0,0,0,1,0,1,0,0,0,0,0,0,0,2));
    for (int i = 0; i < 3; i++)
      cyc_a("sw_wait", ov(0,0,0,1,0,1,0,0,0,1,1,0,0,3));
    dm_ack = 1'b1;
    cyc_a("sw_ack", ov(0,0,0,1,0,1,0,0,0,1,1,0,0,3));

    // jal, jr, nop, illegal; dm_ack held high to confirm it is ignored
    opcode = 6'b000011;
    cyc_a("jal_f", V_FETCH);
    cyc_a("jal_d", ov(0,1,2,1,0,0,2,2,1,0,0,0,0,1));
    opcode = 6'b000000; funct = 6'b001000;
    cyc_a("jr_f", V_FETCH);
    cyc_a("jr_d", ov(0,1,3,1,0,0,0,0,0,0,0,0,0,1));
    funct = 6'b000000;
    cyc_a("nop_f", V_FETCH);
    cyc_a("nop_d", ov(0,0,0,1,0,0,0,0,0,0,0,0,0,1));
    opcode = 6'b111111;
    cyc_a("ill_f", V_FETCH);
    cyc_a("ill_d", ov(0,0,0,1,0,0,0,0,0,0,0,1,0,1));
    opcode = 6'b000000; funct = 6'b111111;
    cyc_a("illfn_f", V_FETCH);
    cyc_a("illfn_d", ov(0,0,0,1,0,0,0,0,0,0,0,1,0,1));
    cyc_a("after_ill", V_FETCH);
    dm_ack = 1'b0;

    // Timeout instance: sw with no ack, then lw acked on the limit cycle
    do_reset();
    opcode = 6'b101011; funct = 6'b000000;
    cyc_b("to_f", V_FETCH);
    cyc_b("to_d", ov(0,0,0,1,0,1,0,0,0,0,0,0,0,1));
    cyc_b("to_e", ov(0,0,0,1,0,1,0,0,0,0,0,0,0,2));
    cyc_b("to_m1", ov(0,0,0,1,0,1,0,0,0,1,1,0,0,3));
    cyc_b("to_m2", ov(0,0,0,1,0,1,0,0,0,1,1,0,1,3));
    #1 chk("nolimit_state", {29'd0, state_a}, 32'd3);
    opcode = 6'b100011;
    cyc_b("to_back_f", V_FETCH);
    cyc_b("lim_d", ov(0,0,0,1,0,1,0,0,0,0,0,0,0,1));
    cyc_b("lim_e", ov(0,0,0,1,0,1,0,0,0,0,0,0,0,2));
    cyc_b("lim_m1", ov(0,0,0,1,0,1,0,0,0,1,0,0,0,3));
    dm_ack = 1'b1;
    cyc_b("lim_m2", ov(0,0,0,1,0,1,0,0,0,1,0,0,0,3));
    dm_ack = 1'b0;
    cyc_b("lim_w", ov(0,0,0,1,0,1,0,1,1,0,0,0,0,4));
    cyc_b("lim_f", V_FETCH);

`ifdef MC_CTRL_PERF_EN
    do_reset();
    opcode = 6'b000000; funct = 6'b000000;
    #1 chk("cnt_rst", {28'd0, cnt_a}, 32'd0);
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); @(posedge clk);
    end
    #1 chk("cnt_wrap", {28'd0, cnt_a}, 32'd1);
    chk("cnt_wide", cnt_b, 32'd17);
    opcode = 6'b111111;
    @(posedge clk); @(posedge clk);
    #1 chk("cnt_ill", {28'd0, cnt_a}, 32'd1);
    opcode = 6'b000011;
    @(posedge clk); @(posedge clk);
    #1 chk("cnt_jal", {28'd0, cnt_a}, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
